// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared AES definitions: FSM state encoding, GF(2^8) helpers and MixColumns coefficients.
// The forward transform constants are only consumed when INV_MIX_FWD_EN is defined.
package inv_mix_columns_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  localparam int NUM_COLS = 4;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  localparam logic [7:0] COEF_01 = 8'h01;
  localparam logic [7:0] COEF_02 = 8'h02;
  localparam logic [7:0] COEF_03 = 8'h03;
  localparam logic [7:0] COEF_09 = 8'h09;
  localparam logic [7:0] COEF_0B = 8'h0B;
  localparam logic [7:0] COEF_0D = 8'h0D;
  localparam logic [7:0] COEF_0E = 8'h0E;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] coef);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = '0;
    pow = a;
    for (int i = 0; i < 8; i++) begin
      if (coef[i]) acc ^= pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_col32.sv
// Combinational (Inv)MixColumns of one 32-bit column; byte a0 sits in bits [31:24].
// fwd_i exists only when INV_MIX_FWD_EN is defined.
module inv_mix_col32
  import inv_mix_columns_seq_pkg::*;
(
`ifdef INV_MIX_FWD_EN
  input  logic        fwd_i,
`endif
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [0:3][7:0] a;
  logic [0:3][7:0] b;
  logic [0:3][7:0] k;

  assign a = col_i;

  // Row r uses the coefficient row rotated right by r: b[r] = sum_j k[(j - r) mod 4] * a[j].
  always_comb begin
`ifdef INV_MIX_FWD_EN
    k = fwd_i ? {COEF_02, COEF_03, COEF_01, COEF_01}
              : {COEF_0E, COEF_0B, COEF_0D, COEF_09};
`else
    k = {COEF_0E, COEF_0B, COEF_0D, COEF_09};
`endif
    for (int r = 0; r < 4; r++) begin
      b[r] = '0;
      for (int j = 0; j < 4; j++) begin
        b[r] ^= gf_mul(a[j], k[2'(j - r)]);
      end
    end
  end

  assign col_o = b;

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per cycle.
// Define INV_MIX_FWD_EN to add the fwd_mode port selecting forward MixColumns.
module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
`ifdef INV_MIX_FWD_EN
  ,
  input  logic         fwd_mode
`endif
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_state_e       fsm_q, fsm_d;
  logic [1:0]       col_cnt_q, col_cnt_d;
  logic [0:3][31:0] work_q, work_d;
`ifdef INV_MIX_FWD_EN
  logic             fwd_q, fwd_d;
`endif

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] mix_in  [COLS_PER_CYCLE];
  logic [31:0] mix_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt_q + 2'(g);
    assign mix_in[g]  = work_q[col_idx[g]];

    inv_mix_col32 u_col (
`ifdef INV_MIX_FWD_EN
      .fwd_i (fwd_q),
`endif
      .col_i (mix_in[g]),
      .col_o (mix_out[g])
    );
  end

  // NOTE: every target gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fsm_d     = fsm_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
`ifdef INV_MIX_FWD_EN
    fwd_d     = fwd_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d    = state_in;
          col_cnt_d = '0;
          fsm_d     = ST_BUSY;
`ifdef INV_MIX_FWD_EN
          fwd_d     = fwd_mode;
`endif
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[col_idx[k]] = mix_out[k];
        end
        // The 2-bit counter wraps to 0 on the final step for every legal width.
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == LAST_CNT) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      col_cnt_q <= '0;
      // NOTE: the working register is reset because state_out is driven straight from it.
      work_q    <= '0;
`ifdef INV_MIX_FWD_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
`ifdef INV_MIX_FWD_EN
      fwd_q     <= fwd_d;
`endif
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench driving three instances (1, 2 and 4 columns per cycle) side by side.
// Define INV_MIX_FWD_EN to also exercise the forward transform.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] state_in  [3];
  logic [127:0] state_out [3];
`ifdef INV_MIX_FWD_EN
  logic [2:0]   fwd_mode;
`endif

  int           n_checks;
  int           n_fail;
  int           n_out [3];
  logic [127:0] sb [3][$];
  logic [127:0] mon_exp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g])
`ifdef INV_MIX_FWD_EN
      ,
      .fwd_mode  (fwd_mode[g])
`endif
    );
  end

  // Reference arithmetic: carry-less product followed by polynomial reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011B << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c, input logic fwd);
    logic [7:0] inv_m [4][4];
    logic [7:0] fwd_m [4][4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [31:0] res;
    inv_m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
              '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    fwd_m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
              '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      b = '0;
      for (int j = 0; j < 4; j++) b ^= gmul(a[j], fwd ? fwd_m[r][j] : inv_m[r][j]);
      res[31-8*r -: 8] = b;
    end
    return res;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s, input logic fwd);
    logic [127:0] res;
    for (int c = 0; c < 4; c++) res[127-32*c -: 32] = model_col(s[127-32*c -: 32], fwd);
    return res;
  endfunction

  // One operation on instance d; entered and left at posedge+1 with the instance idle.
  task automatic run_op(input int d, input logic [127:0] s, input logic [127:0] exp, input string tag);
    int lat;
    n_checks++;
    if (in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready dut%0d: in_ready=%b, expected 1", tag, d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    state_in[d] = s;
    sb[d].push_back(exp);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    state_in[d] = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid[d] !== 1'b1 && lat < 20);
    n_checks++;
    if (lat != 4 / (1 << d)) begin
      n_fail++;
      $display("FAIL %s_latency dut%0d: out_valid after %0d cycles, expected %0d", tag, d, lat, 4 / (1 << d));
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_return dut%0d: in_ready=%b out_valid=%b, expected 1 0", tag, d, in_ready[d], out_valid[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready dut%0d: got %b, expected 1", d, in_ready[d]);
      end
      n_checks++;
      if (out_valid[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_valid dut%0d: got %b, expected 0", d, out_valid[d]);
      end
      n_checks++;
      if (state_out[d] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_state_out dut%0d: got %h, expected 0", d, state_out[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_known_vectors();
    run_op(0, {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101},
              {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101}, "vec_single_col");
    for (int d = 0; d < 3; d++) begin
      run_op(d, {32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8},
                {32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c}, "vec_full_state");
    end
  endtask

  task automatic test_random();
    logic [127:0] s;
    for (int d = 0; d < 3; d++) begin
      run_op(d, 128'h0, 128'h0, "zero");
      run_op(d, {128{1'b1}}, model_state({128{1'b1}}, 1'b0), "ones");
      repeat (3) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        run_op(d, s, model_state(s, 1'b0), "random");
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] s;
    logic [127:0] exp;
    int           wait_cyc;
    s   = {$urandom, $urandom, $urandom, $urandom};
    exp = model_state(s, 1'b0);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    state_in[0]  = s;
    sb[0].push_back(exp);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_cyc = 0;
    while (out_valid[0] !== 1'b1 && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    n_checks++;
    if (out_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_reach_done dut0: out_valid=%b, expected 1", out_valid[0]);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      state_in[0] = {$urandom, $urandom, $urandom, $urandom};
      n_checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_handshake cycle %0d: out_valid=%b in_ready=%b, expected 1 0", i, out_valid[0], in_ready[0]);
      end
      n_checks++;
      if (state_out[0] !== exp) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: state_out=%h, expected %h", i, state_out[0], exp);
      end
      @(posedge clk); #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b, expected 1 0", in_ready[0], out_valid[0]);
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (sb[0].size() != 0 || in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_extra: pending=%0d in_ready=%b, expected 0 1", sb[0].size(), in_ready[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    in_valid[0] = 1'b1;
    state_in[0] = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || state_out[0] !== 128'h0) begin
      n_fail++;
      $display("FAIL midbusy_reset: in_ready=%b out_valid=%b state_out=%h, expected 1 0 0",
               in_ready[0], out_valid[0], state_out[0]);
    end
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid[0] === 1'b1) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midbusy_no_result: out_valid seen=%b, expected 0", saw_valid);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int accepts;
    int last_acc;
    int cyc;
    for (int d = 0; d < 3; d++) begin
      base     = n_out[d];
      accepts  = 0;
      last_acc = 0;
      cyc      = 0;
      in_valid[d] = 1'b1;
      state_in[d] = {$urandom, $urandom, $urandom, $urandom};
      while (accepts < 5 && cyc < 200) begin
        if (in_ready[d] === 1'b1) begin
          sb[d].push_back(model_state(state_in[d], 1'b0));
          if (accepts > 0) begin
            n_checks++;
            if (cyc - last_acc != 4 / (1 << d) + 2) begin
              n_fail++;
              $display("FAIL b2b_period dut%0d: %0d cycles, expected %0d", d, cyc - last_acc, 4 / (1 << d) + 2);
            end
          end
          last_acc = cyc;
          accepts++;
        end
        @(posedge clk); #1;
        cyc++;
        state_in[d] = {$urandom, $urandom, $urandom, $urandom};
        if (accepts == 5) in_valid[d] = 1'b0;
      end
      in_valid[d] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      n_checks++;
      if (n_out[d] - base != 5 || sb[d].size() != 0) begin
        n_fail++;
        $display("FAIL b2b_count dut%0d: outputs=%0d pending=%0d, expected 5 0", d, n_out[d] - base, sb[d].size());
      end
    end
  endtask

`ifdef INV_MIX_FWD_EN
  task automatic test_fwd();
    fwd_mode[0] = 1'b1;
    run_op(0, {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101},
              {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101}, "fwd_mix");
    fwd_mode[0] = 1'b0;
    run_op(0, {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101},
              {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101}, "fwd_roundtrip");
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    for (int d = 0; d < 3; d++) begin
      state_in[d] = '0;
      n_out[d]    = 0;
    end
`ifdef INV_MIX_FWD_EN
    fwd_mode = '0;
`endif

    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          if (rst === 1'b0 && out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
            n_checks++;
            if (sb[d].size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_output dut%0d: got %h, expected no output", d, state_out[d]);
            end else begin
              mon_exp = sb[d].pop_front();
              if (state_out[d] !== mon_exp) begin
                n_fail++;
                $display("FAIL result dut%0d: got %h, expected %h", d, state_out[d], mon_exp);
              end
            end
            n_out[d]++;
          end
        end
      end
    join_none

    test_reset();
    test_known_vectors();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef INV_MIX_FWD_EN
    test_fwd();
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_seq.md
INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: state_in is valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept a state.
REQ-006 SHALL have port state_in, input, 128: AES state; column c = bits [127-32c -: 32]; within a column, byte a0 = [31:24] through a3 = [7:0].
REQ-007 SHALL have port out_valid, output, 1: state_out holds a result.
REQ-008 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-009 SHALL have port state_out, output, 128: InvMixColumns(state_in), with the same column and byte layout as state_in.
REQ-010 SHALL have port fwd_mode, input, 1, present only when INV_MIX_FWD_EN is defined: 1 selects forward MixColumns.

Function
REQ-011 SHALL compute each output column as follows (GF(2^8), polynomial 0x11B):
- b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
- b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
- b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
- b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
REQ-012 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL, in IDLE, register state_in into the working register on in_valid, clear the column counter and go to BUSY.
REQ-015 SHALL, in BUSY, each cycle transform COLS_PER_CYCLE columns in place, starting at column 0 in ascending order, and advance the counter by COLS_PER_CYCLE.
REQ-016 SHALL leave BUSY for DONE in the cycle the last column is written; the counter wraps to 0.
REQ-017 SHALL assert out_valid only in DONE, with state_out driven directly from the working register.
REQ-018 SHALL, in DONE, return to IDLE on out_ready and otherwise hold state_out and out_valid stable.
REQ-019 SHALL assert out_valid 4/COLS_PER_CYCLE cycles after the accept edge; in_ready reasserts one cycle after the out_valid&&out_ready edge; there is no overlap between states.
REQ-020 SHALL ignore in_valid outside IDLE and SHALL ignore out_ready outside DONE.
REQ-021 SHALL not require in_valid to be held after acceptance; a change to state_in after acceptance SHALL not affect the result.

Reset
REQ-022 SHALL, on rst high at a clock edge, force FSM=IDLE, counter=0, working register=0, in_ready=1, out_valid=0, state_out=0.
REQ-023 SHALL, when rst is asserted mid-BUSY or in DONE, discard the operation with no partial output; reset SHALL take priority over every other event on the same edge.

Configuration
REQ-024 SHALL, with INV_MIX_FWD_EN defined, add port fwd_mode, sampled at accept and held for the whole operation; fwd_mode=1 applies coefficients {02,03,01,01} rotated per row, fwd_mode=0 applies the inverse.
REQ-025 SHALL, without INV_MIX_FWD_EN, omit the fwd_mode port and always perform the inverse transform.

Structure
REQ-026 SHALL place in the shared AES package: the FSM state enum, the reduction polynomial constant 8'h1B, the xtime function, and the coefficient constants 0x09/0x0B/0x0D/0x0E.
REQ-027 SHALL instantiate COLS_PER_CYCLE copies of one purely combinational sub-module, inv_mix_col32 (32-bit in, 32-bit out, plus a fwd input when INV_MIX_FWD_EN is defined).

Verification
REQ-028 SHALL cover: column 0 = 8e4da1bc, other columns 01010101, in_valid for 1 cycle, COLS_PER_CYCLE=1 -> out_valid after 4 cycles with column 0 = db135345 and columns 1-3 = 01010101.
REQ-029 SHALL cover: state = {9fdc589d, c6c6c6c6, d5d5d7d6, 4d7ebdf8} -> {f20a225c, c6c6c6c6, d4d4d4d5, 2d26314c}, at COLS_PER_CYCLE 1, 2 and 4 with latencies 4, 2 and 1.
REQ-030 SHALL cover: out_ready held low 10 cycles in DONE -> state_out stable, in_ready=0, and a new in_valid is ignored.
REQ-031 SHALL cover: rst pulsed in the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, state_out=0, and no result emerges.
REQ-032 SHALL cover: with INV_MIX_FWD_EN, fwd_mode=1 on column db135345 gives 8e4da1bc, and feeding that back with fwd_mode=0 returns db135345.
REQ-033 SHALL cover: back-to-back operations with in_valid held high and out_ready=1 -> one operation per 4/COLS_PER_CYCLE+2 cycles and no lost or duplicated results.
